// File: rtl/pa_uart_tx_sched.sv
// Line-atomic UART transmit scheduler: round-robin arbitration of NUM_REQ byte
// streams onto one 8N1 txd line, holding the grant until EOL, burst limit or idle timeout.
module pa_uart_tx_sched #(
  parameter int          NUM_REQ   = 2,
  parameter int          CLK_DIV   = 16,
  parameter int          MAX_BURST = 128,
  parameter int          IDLE_TMO  = 64,
  parameter logic [7:0]  EOL_CHAR  = 8'h0a
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 txd_o,
  output logic [1:0]           dbg_state_o
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_TMO + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TMO - 1);
  localparam logic [OW-1:0] LAST_REQ  = OW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q;
  logic            owner_vld_q;
  logic [OW-1:0]   rr_q;
  logic [BW-1:0]   burst_q;
  logic [IW-1:0]   idle_q;
  logic [DW-1:0]   div_q;
  logic [2:0]      bit_q;
  logic [7:0]      shreg_q;
  logic            eol_q;

  logic            owner_req;
  logic [7:0]      owner_data;
  logic            arb_found;
  logic [OW-1:0]   arb_idx;
  int              cand;
  logic            hs, div_done, rel_stop, tmo, rel, arb;

  assign owner_req  = req_valid_i[owner_q];
  assign owner_data = req_data_i[8*owner_q +: 8];

  // First requester at or after rr_q, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!arb_found && req_valid_i[OW'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = OW'(cand);
      end
    end
  end

  // Handshake: a byte moves when req_valid_i[i] & req_ready_o[i] are both high at
  // a rising edge; ready is only offered to the owner while the line is idle, and
  // the requester must hold its data stable while valid is high and unaccepted.
  assign hs       = (state_q == ST_IDLE) && owner_vld_q && owner_req;
  assign div_done = (div_q == DIV_LAST);
  assign rel_stop = (state_q == ST_STOP) && div_done && (eol_q || (burst_q == BURST_MAX));
  assign tmo      = (state_q == ST_IDLE) && owner_vld_q && !owner_req && (idle_q == IDLE_LAST);
  assign rel      = rel_stop || tmo;
  assign arb      = (state_q == ST_IDLE) && !owner_vld_q && arb_found;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    busy_o      = 1'b0;
    txd_o       = 1'b1;
    req_ready_o = '0;
    grant_o     = '0;
    if (owner_vld_q) grant_o[owner_q] = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (owner_vld_q) req_ready_o[owner_q] = 1'b1;
        if (hs) state_d = ST_START;
      end
      ST_START: begin
        busy_o = 1'b1;
        txd_o  = 1'b0;
        if (div_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        busy_o = 1'b1;
        txd_o  = shreg_q[0];
        if (div_done && (bit_q == 3'd7)) state_d = ST_STOP;
      end
      ST_STOP: begin
        busy_o = 1'b1;
        if (div_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dbg_state_o = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      rr_q        <= '0;
      burst_q     <= '0;
      idle_q      <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      eol_q       <= 1'b0;
    end else begin
      if (state_q == ST_IDLE || div_done) div_q <= '0;
      else                                div_q <= div_q + DW'(1);

      if (hs) begin
        shreg_q <= owner_data;
        eol_q   <= (owner_data == EOL_CHAR);
        bit_q   <= '0;
      end else if (state_q == ST_DATA && div_done) begin
        shreg_q <= {1'b0, shreg_q[7:1]};
        if (bit_q != 3'd7) bit_q <= bit_q + 3'd1;
      end

      if (rel)     burst_q <= '0;
      else if (hs) burst_q <= burst_q + BW'(1);

      // Idle time only accrues while the owner holds an idle line with nothing to send.
      if (rel || (owner_vld_q && owner_req))       idle_q <= '0;
      else if (state_q == ST_IDLE && owner_vld_q)  idle_q <= idle_q + IW'(1);

      if (rel) begin
        owner_vld_q <= 1'b0;
        rr_q        <= (owner_q == LAST_REQ) ? '0 : owner_q + OW'(1);
      end else if (arb) begin
        owner_q     <= arb_idx;
        owner_vld_q <= 1'b1;
      end
    end
  end

endmodule
